seg_scan_display: RTL
=====================

SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 Parameter NUM_DIGITS, default 8, number of 7-segment digits scanned (1..16).
REQ-002 Parameter NUM_CH, default 4, number of selectable hex value channels (1..8).
REQ-003 Parameter CLK_DIV, default 50000, clocks per digit slot (>=1).
REQ-004 Port clk  in  1  single system clock, all state on rising edge.
REQ-005 Port rst  in  1  reset, synchronous, active-high.
REQ-006 Port ch_data  in  NUM_CH*4*NUM_DIGITS  flattened channel values; channel k occupies bits [k*4*NUM_DIGITS +: 4*NUM_DIGITS].
REQ-007 Port ch_sel  in  max(1,clog2(NUM_CH))  channel to display.
REQ-008 Port blank_lead  in  1  leading-zero blanking enable.
REQ-009 Port freeze  in  1  hold current snapshot.
REQ-010 Port dp_en  in  NUM_DIGITS  per-digit decimal point enable.
REQ-011 Port AN  out  NUM_DIGITS  digit enables, active-low, one-hot or all-high.
REQ-012 Port SEG  out  8  segments, active-low, SEG[7]=dp, SEG[6:0]=g..a.
REQ-013 Port frame_done  out  1  one-cycle pulse when last digit slot ends.

Function
REQ-014 Prescaler SHALL count 0..CLK_DIV-1 and wrap; tick SHALL be asserted in the cycle prescaler equals CLK_DIV-1 (every cycle when CLK_DIV=1).
REQ-015 Digit index idx SHALL advance by one on tick, wrapping NUM_DIGITS-1 -> 0.
REQ-016 frame_done SHALL pulse for exactly the tick cycle in which idx equals NUM_DIGITS-1.
REQ-017 Snapshot register SHALL load the selected channel in the first cycle after reset release and on every frame_done cycle with freeze=0; otherwise it SHALL hold.
REQ-018 ch_sel >= NUM_CH SHALL load an all-zero snapshot.
REQ-019 ch_data or ch_sel changes mid-frame SHALL NOT affect displayed digits until the next snapshot load (tear-free).
REQ-020 AN and SEG SHALL be registered: one cycle after idx=i, AN = ~(1<<i) and SEG = {~dp_en[i], decode(snapshot nibble i)}.
REQ-021 Decoder SHALL map 0-F to standard hex glyphs (b,d lowercase), active-low.
REQ-022 With blank_lead=1, digit i>0 SHALL be blanked (AN bit i high, SEG=8'hFF) when snapshot nibbles i..NUM_DIGITS-1 are all zero; digit 0 SHALL never be blanked.
REQ-023 freeze asserted coincident with frame_done SHALL suppress that load.

Reset
REQ-024 While rst=1: prescaler=0, idx=0, snapshot=0, AN=all ones, SEG=8'hFF, frame_done=0.
REQ-025 Reset asserted mid-frame SHALL take effect on the next edge and restart scanning at digit 0 with a fresh snapshot load after release.

Structure
REQ-026 Shared package SHALL hold the 16-entry active-low glyph constants and the SEG blank constant 8'hFF.
REQ-027 Hex-to-segment decode SHALL be a combinational sub-module hex7seg (4-bit in, 7-bit active-low out).

Verification (NUM_DIGITS=8, NUM_CH=2, CLK_DIV=4)
REQ-028 Reset 3 cycles -> AN=8'hFF, SEG=8'hFF; release with ch0=32'h1234_5678, ch_sel=0, dp_en=0 -> one cycle later AN=8'hFE, SEG=8'h80.
REQ-029 Free-run 32 cycles -> AN steps FE,FD,FB,F7,EF,DF,BF,7F every 4 cycles then FE; digit 3 shows SEG=8'h92; frame_done pulses once per 32 cycles.
REQ-030 Change ch0 to 32'hFFFF_FFFF while idx=3 -> digits 4..7 still show 4,3,2,1; after frame_done all digits show 8'h8E.
REQ-031 freeze=1 across frame_done with ch_sel switched to 1 -> old values persist; freeze=0 -> channel 1 appears after next frame_done.
REQ-032 ch0=32'h0000_00A0, blank_lead=1 -> digits 7..2 AN bit high; digit1 SEG=8'h88; digit0 SEG=8'hC0; dp_en=8'h01 -> digit0 SEG=8'h40.
REQ-033 rst pulse at idx=5 -> next cycle AN=8'hFF; after release scan restarts at digit 0; ch_sel=3 (out of range, widened bench) -> all digits 8'hC0.

Source files
------------

// File: rtl/seg_scan_display_pkg.sv
// Shared constants for the multiplexed 7-segment scanner: active-low hex glyphs
// and the all-segments-off pattern.
package seg_scan_display_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Index = hex value, bits = g..a, active-low; b and d are lowercase
    localparam logic [6:0] GLYPHS [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low 7-segment glyph (g..a).
module hex7seg
    import seg_scan_display_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg_n_c
);

    assign seg_n_c = GLYPHS[hex];

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed 7-segment scanner: snapshots one hex channel per frame and
// drives one digit per prescaler slot with registered AN/SEG outputs.
module seg_scan_display
    import seg_scan_display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CLK_DIV    = 50000,
    localparam int unsigned SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH*4*NUM_DIGITS-1:0] ch_data,
    input  logic [SEL_W-1:0]               ch_sel,
    input  logic                           blank_lead,
    input  logic                           freeze,
    input  logic [NUM_DIGITS-1:0]          dp_en,
    output logic [NUM_DIGITS-1:0]          AN,
    output logic [7:0]                     SEG,
    output logic                           frame_done
);

    localparam int unsigned VAL_W = 4 * NUM_DIGITS;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

    logic [PRE_W-1:0]      presc_q, presc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [VAL_W-1:0]      snap_q, snap_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [7:0]            seg_q, seg_d;
    logic                  frame_done_q, frame_done_d;
    logic                  load_pend_q, load_pend_d;

    logic                  tick_c;
    logic                  load_c;
    logic [VAL_W-1:0]      chan_c;
    logic [NUM_DIGITS-1:0] lead_zero_c;
    logic                  zero_above_c;
    logic [3:0]            nibble_c;
    logic                  dp_c;
    logic                  lz_c;
    logic                  blank_c;
    logic [6:0]            glyph_c;

    // Slot timing; frame_done is registered one cycle early so it lands on the last tick
    always_comb begin
        tick_c       = (presc_q == PRE_LAST);
        presc_d      = tick_c ? '0 : presc_q + PRE_W'(1);
        idx_d        = idx_q;
        if (tick_c) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
        frame_done_d = (presc_d == PRE_LAST) && (idx_d == IDX_LAST);
    end

    // Channel mux; unmatched selects fall through to zero
    always_comb begin
        chan_c = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (ch_sel == SEL_W'(c)) begin
                chan_c = ch_data[c*VAL_W +: VAL_W];
            end
        end
    end

    always_comb begin
        load_pend_d = 1'b0;
        load_c      = load_pend_q | (frame_done_q & ~freeze);
        snap_d      = load_c ? chan_c : snap_q;
    end

    // lead_zero_c[i]: nibbles i..top of the snapshot being displayed are all zero
    always_comb begin
        lead_zero_c  = '0;
        zero_above_c = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            zero_above_c   = zero_above_c & (snap_d[4*i +: 4] == 4'h0);
            lead_zero_c[i] = zero_above_c;
        end
    end

    always_comb begin
        nibble_c = '0;
        dp_c     = 1'b0;
        lz_c     = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nibble_c = snap_d[4*i +: 4];
                dp_c     = dp_en[i];
                lz_c     = lead_zero_c[i];
            end
        end
    end

    hex7seg u_hex7seg (
        .hex     (nibble_c),
        .seg_n_c (glyph_c)
    );

    always_comb begin
        blank_c = blank_lead & lz_c & (idx_q != '0);
        an_d    = '1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            an_d[i] = blank_c | (idx_q != IDX_W'(i));
        end
        seg_d   = blank_c ? SEG_BLANK : {~dp_c, glyph_c};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q      <= '0;
            idx_q        <= '0;
            snap_q       <= '0;
            an_q         <= '1;
            seg_q        <= SEG_BLANK;
            frame_done_q <= 1'b0;
            load_pend_q  <= 1'b1;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            snap_q       <= snap_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
            load_pend_q  <= load_pend_d;
        end
    end

    assign AN         = an_q;
    assign SEG        = seg_q;
    assign frame_done = frame_done_q;

endmodule
